// File: rtl/sort_block_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sort_block_ctrl
// Purpose  : Stream front/back end for the merge_sort_top byte sorter on the
//            BWT path. Gathers up to N bytes from a valid/ready stream,
//            pads short blocks with PAD_BYTE, resets and kicks the sorter,
//            waits its fixed latency, captures the sorted block, and
//            streams back only the real (non-pad) bytes.
// Ports    : clk, rst_n (async, active low)
//            in_valid/in_ready/in_data/in_last    - input byte stream
//            out_valid/out_ready/out_data/out_last - sorted byte stream
//            busy                                 - block in flight
//            sort_rst/sort_start/sort_din/sort_dout - sorter handshake
// Revision : 1.0 - initial release
// ============================================================================
module sort_block_ctrl #(
    parameter int         N        = 8,
    parameter int         SORT_LAT = 20,
    parameter logic [7:0] PAD_BYTE = 8'hFF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [7:0]     in_data,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [7:0]     out_data,
    output logic           out_last,
    output logic           busy,
    output logic           sort_rst,
    output logic           sort_start,
    output logic [N*8-1:0] sort_din,
    input  logic [N*8-1:0] sort_dout
);

    // Counter width covers 0..N so len can hold a full block.
    localparam int c_cnt_w = $clog2(N + 1);
    localparam int c_lat_w = (SORT_LAT > 1) ? $clog2(SORT_LAT) : 1;

    localparam logic [c_cnt_w-1:0] c_last_slot = c_cnt_w'(N - 1);
    localparam logic [c_lat_w-1:0] c_wait_init = c_lat_w'(SORT_LAT - 1);

    typedef enum logic [2:0] {
        S_FILL    = 3'd0,
        S_SRST    = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4,
        S_DRAIN   = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [N*8-1:0]       r_blk;
    logic [N*8-1:0]       r_obuf;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   r_len;
    logic [c_cnt_w-1:0]   r_idx;
    logic [c_lat_w-1:0]   r_wait;
    logic                 w_block_close;
    logic                 w_is_last;

    // In FILL in_ready is always high, so in_valid alone is an accept.
    assign w_block_close = in_valid && (in_last || (r_cnt == c_last_slot));
    assign w_is_last     = (r_idx == (r_len - 1'b1));

    // The sorter sees the gather buffer directly; it cannot change between
    // SRST and the end of WAIT because only FILL and DRAIN write it.
    assign sort_din = r_blk;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_data     = 8'h00;
        out_last     = 1'b0;
        sort_rst     = 1'b0;
        sort_start   = 1'b0;
        busy         = 1'b1;

        case (r_state)
            S_FILL: begin
                in_ready = 1'b1;
                busy     = (r_cnt != '0);
                if (w_block_close) begin
                    w_next_state = S_SRST;
                end
            end
            S_SRST: begin
                sort_rst     = 1'b1;
                w_next_state = S_START;
            end
            S_START: begin
                sort_start   = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait == '0) begin
                    w_next_state = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                out_last  = w_is_last;
                for (int i = 0; i < N; i++) begin
                    if (r_idx == c_cnt_w'(i)) begin
                        out_data = r_obuf[8*i +: 8];
                    end
                end
                if (out_ready && w_is_last) begin
                    w_next_state = S_FILL;
                end
            end
            default: begin
                w_next_state = S_FILL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk  <= {N{PAD_BYTE}};
            r_obuf <= '0;
            r_cnt  <= '0;
            r_len  <= '0;
            r_idx  <= '0;
            r_wait <= '0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (in_valid) begin
                        for (int i = 0; i < N; i++) begin
                            if (r_cnt == c_cnt_w'(i)) begin
                                r_blk[8*i +: 8] <= in_data;
                            end
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (w_block_close) begin
                            r_len <= r_cnt + 1'b1;
                        end
                    end
                end
                S_START: begin
                    r_wait <= c_wait_init;
                end
                S_WAIT: begin
                    if (r_wait != '0) begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_obuf <= sort_dout;
                    r_idx  <= '0;
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (w_is_last) begin
                            // Refill with pads so a short next block is
                            // padded without any extra clear cycle.
                            r_blk <= {N{PAD_BYTE}};
                            r_cnt <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sort_block_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_block_ctrl
// Purpose  : Self-checking bench for sort_block_ctrl. Contains a behavioural
//            sorter partner with fixed latency and a block-level reference
//            model (split stream into blocks, sort real bytes by value).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sort_block_ctrl;

    localparam int         N        = 8;
    localparam int         SORT_LAT = 20;
    localparam logic [7:0] PAD      = 8'hFF;
    localparam logic [63:0] GARBAGE = 64'hDEAD_BEEF_0BAD_F00D;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           in_valid  = 1'b0;
    logic [7:0]     in_data   = 8'h00;
    logic           in_last   = 1'b0;
    logic           out_ready = 1'b0;
    logic [N*8-1:0] sort_dout = GARBAGE;
    logic           in_ready;
    logic           out_valid;
    logic [7:0]     out_data;
    logic           out_last;
    logic           busy;
    logic           sort_rst;
    logic           sort_start;
    logic [N*8-1:0] sort_din;

    sort_block_ctrl #(.N(N), .SORT_LAT(SORT_LAT), .PAD_BYTE(PAD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .sort_rst   (sort_rst),
        .sort_start (sort_start),
        .sort_din   (sort_din),
        .sort_dout  (sort_dout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [7:0]  cur[$];
    logic [63:0] din_q[$];
    logic [7:0]  exp_q[$];
    logic        exp_last_q[$];
    int          close_q[$];
    int          cyc = 0;
    int          n_starts = 0;
    int          n_blocks = 0;
    int          out_mode = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Called at the negedge before the edge that accepts the byte.
    task automatic model_accept(input logic [7:0] d, input bit last);
        logic [63:0] din;
        cur.push_back(d);
        if (last || cur.size() == N) begin
            din = {N{PAD}};
            foreach (cur[i]) din[8*i +: 8] = cur[i];
            din_q.push_back(din);
            for (int v = 0; v < 256; v++)
                foreach (cur[i])
                    if (cur[i] == 8'(v)) begin
                        exp_q.push_back(8'(v));
                        exp_last_q.push_back(1'b0);
                    end
            exp_last_q[exp_last_q.size()-1] = 1'b1;
            close_q.push_back(cyc + 1);
            n_blocks++;
            cur.delete();
        end
    endtask

    // ---------------- sorter partner ----------------
    // Sorted data appears exactly SORT_LAT edges after the edge that sees
    // sort_start; before that the output is garbage.
    initial begin
        int          cd;
        logic [63:0] pend;
        logic [63:0] srt;
        int          pos;
        cd = 0;
        pend = '0;
        forever begin
            @(negedge clk);
            if (cd > 0) begin
                cd--;
                if (cd == 0) sort_dout = pend;
            end
            if (rst_n && sort_rst) begin
                sort_dout = GARBAGE;
                cd = 0;
            end else if (rst_n && sort_start) begin
                srt = '0;
                pos = 0;
                for (int v = 0; v < 256; v++)
                    for (int i = 0; i < N; i++)
                        if (sort_din[8*i +: 8] == 8'(v)) begin
                            srt[8*pos +: 8] = 8'(v);
                            pos++;
                        end
                pend = srt;
                cd = SORT_LAT + 1;
            end
        end
    end

    // ---------------- downstream ready ----------------
    initial forever begin
        @(posedge clk);
        #1;
        case (out_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = !out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- monitor ----------------
    initial begin
        bit         prev_valid;
        bit         prev_ready;
        bit         prev_srst;
        logic [7:0] prev_data;
        bit         prev_last;
        prev_valid = 0; prev_ready = 0; prev_srst = 0; prev_data = 0; prev_last = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (sort_start) begin
                    n_starts++;
                    check("start_after_srst", 64'(prev_srst), 64'd1);
                    check("in_ready_start", 64'(in_ready), 64'd0);
                    if (din_q.size() == 0) check("start_unexpected", 64'd1, 64'd0);
                    else check("sort_din", sort_din, din_q.pop_front());
                end
                if (!in_ready) check("busy", 64'(busy), 64'd1);
                if (out_valid) begin
                    check("in_ready_drain", 64'(in_ready), 64'd0);
                    if (!prev_valid) begin
                        if (close_q.size() == 0) check("ov_unexpected", 64'd1, 64'd0);
                        else check("latency", 64'(cyc), 64'(close_q.pop_front() + SORT_LAT + 3));
                    end
                    if (prev_valid && !prev_ready) begin
                        check("hold_data", 64'(out_data), 64'(prev_data));
                        check("hold_last", 64'(out_last), 64'(prev_last));
                    end
                    if (exp_q.size() == 0) begin
                        check("extra_byte", 64'd1, 64'd0);
                    end else begin
                        check("out_data", 64'(out_data), 64'(exp_q[0]));
                        check("out_last", 64'(out_last), 64'(exp_last_q[0]));
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            void'(exp_last_q.pop_front());
                        end
                    end
                end
            end
            prev_valid = out_valid && rst_n;
            prev_ready = out_ready;
            prev_srst  = sort_rst && rst_n;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] d, input bit last);
        bit acc;
        int guard;
        acc = 0;
        guard = 0;
        while (!acc) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = d;
            in_last  = last;
            acc = in_ready && rst_n;
            if (acc) model_accept(d, last);
            guard++;
            if (!acc && guard > 500) begin
                check("send_timeout", 64'd1, 64'd0);
                acc = 1;
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input bit gaps);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], i == s.len() - 1);
            if (gaps && $urandom_range(0, 3) == 0) idle();
        end
        idle();
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || close_q.size() != 0 || din_q.size() != 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int    s0;
        int    ov_cnt;
        int    len;
        string rs;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sort_rst", 64'(sort_rst), 64'd0);
        check("rst_sort_start", 64'(sort_start), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_sort_din", sort_din, {N{PAD}});

        // Full block, last on the 8th byte.
        out_mode = 0;
        s0 = n_starts;
        send_str("cadbabab", 0);
        wait_drain();
        check("one_start_cadbabab", 64'(n_starts - s0), 64'd1);

        // Short block: busy with bytes pending, pads in slots 5..7.
        out_mode = 2;
        send_byte("t", 0);
        idle();
        check("busy_partial", 64'(busy), 64'd1);
        check("in_ready_partial", 64'(in_ready), 64'd1);
        send_str("woab", 0);
        wait_drain();

        // Overflow into a second block.
        out_mode = 0;
        s0 = n_starts;
        send_str("hgfedcbaxyz", 0);
        wait_drain();
        check("two_starts_overflow", 64'(n_starts - s0), 64'd2);

        // Back-pressure every other cycle.
        out_mode = 1;
        send_str("zyxwvuts", 0);
        wait_drain();

        // Reset in the middle of WAIT discards the block.
        out_mode = 0;
        send_str("qp", 0);
        s0 = 0;
        while (sort_start !== 1'b1 && s0 < 100) begin
            @(negedge clk);
            s0++;
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        cur.delete(); din_q.delete(); exp_q.delete(); exp_last_q.delete(); close_q.delete();
        @(negedge clk);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        ov_cnt = 0;
        repeat (SORT_LAT + 10) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        check("no_out_after_reset", 64'(ov_cnt), 64'd0);
        send_str("ba", 0);
        wait_drain();

        // Randomized blocks, including literal PAD-valued bytes.
        out_mode = 2;
        for (int k = 0; k < 8; k++) begin
            len = $urandom_range(1, 13);
            rs = "";
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 4) == 0) rs = {rs, string'(8'hFF)};
                else rs = {rs, string'(8'($urandom_range(1, 254)))};
            end
            send_str(rs, 1);
            wait_drain();
        end

        check("total_starts", 64'(n_starts), 64'(n_blocks));
        check("queues_empty", 64'(exp_q.size() + close_q.size() + din_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
